// File: rtl/ngx_http_parse_time_mul_arb.sv
// ngx_http_parse_time_mul_arb: round-robin arbiter feeding a shared two-stage 21x18 signed multiplier
module ngx_http_parse_time_mul_arb #(
  parameter int NREQ = 4,
  parameter int A_W  = 21,
  parameter int B_W  = 18,
  parameter int P_W  = 40
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_id,
  output logic [P_W-1:0]      rsp_p,
  output logic [1:0]          inflight
);
  logic [1:0]            ptr_q, ptr_d, cand, s1_id_q, s1_id_d, s2_id_q, s2_id_d;
  logic                  cand_v, adv1, adv2, xfer;
  logic                  s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [A_W-1:0]        s1_a_q, s1_a_d;
  logic [B_W-1:0]        s1_b_q, s1_b_d;
  logic [P_W-1:0]        s2_p_q, s2_p_d;
  logic signed [P_W-1:0] a_x, b_x, prod;
  // first valid requester at or after the pointer wins; scanning downward lets the nearest overwrite
  always_comb begin
    cand_v = 1'b0;
    cand   = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr_q) + k) % NREQ]) begin
        cand_v = 1'b1;
        cand   = 2'((int'(ptr_q) + k) % NREQ);
      end
  end
  assign adv2      = !s2_v_q | rsp_ready;
  assign adv1      = !s1_v_q | adv2;
  assign xfer      = ap_rst_n & cand_v & adv1;
  assign req_ready = xfer ? NREQ'(1) << cand : '0;
  assign a_x       = P_W'($signed({1'b0, s1_a_q}));
  assign b_x       = P_W'($signed(s1_b_q));
  assign prod      = a_x * b_x;
  // next state: S1 loads on a transfer, S2 follows S1 whenever the response slot can move
  always_comb begin
    ptr_d   = xfer ? ((cand == 2'(NREQ - 1)) ? 2'd0 : cand + 2'd1) : ptr_q;
    s1_v_d  = xfer | (s1_v_q & !adv1);
    s1_id_d = xfer ? cand : s1_id_q;
    s1_a_d  = xfer ? req_a[cand*A_W +: A_W] : s1_a_q;
    s1_b_d  = xfer ? req_b[cand*B_W +: B_W] : s1_b_q;
    s2_v_d  = adv2 ? s1_v_q : s2_v_q;
    s2_id_d = adv2 ? s1_id_q : s2_id_q;
    s2_p_d  = (adv2 & s1_v_q) ? prod : s2_p_q;
  end
  // pipeline and pointer registers, cleared immediately on reset
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_q   <= '0;
      s1_v_q  <= 1'b0;
      s1_id_q <= '0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s2_v_q  <= 1'b0;
      s2_id_q <= '0;
      s2_p_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      s1_v_q  <= s1_v_d;
      s1_id_q <= s1_id_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s2_v_q  <= s2_v_d;
      s2_id_q <= s2_id_d;
      s2_p_q  <= s2_p_d;
    end
  end
  assign rsp_valid = s2_v_q;
  assign rsp_id    = s2_id_q;
  assign rsp_p     = s2_p_q;
  assign inflight  = {1'b0, s1_v_q} + {1'b0, s2_v_q};
endmodule
